// File: rtl/dcache_dual_req_arbiter.sv
// Serialises a dual-issue load/store pair onto a single data-cache port in
// program order and steers each in-order response back to its issuing slot.
module dcache_dual_req_arbiter #(
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pms_req_01,
   input  logic        pms_wr_01,
   input  logic [1:0]  pms_size_01,
   input  logic [3:0]  pms_wstrb_01,
   input  logic [31:0] pms_addr_01,
   input  logic [31:0] pms_wdata_01,
   input  logic        pms_req_02,
   input  logic        pms_wr_02,
   input  logic [1:0]  pms_size_02,
   input  logic [3:0]  pms_wstrb_02,
   input  logic [31:0] pms_addr_02,
   input  logic [31:0] pms_wdata_02,
   output logic        pms_addr_ok,
   output logic        data_req,
   output logic        data_wr,
   output logic [1:0]  data_size,
   output logic [3:0]  data_wstrb,
   output logic [31:0] data_addr,
   output logic [31:0] data_wdata,
   input  logic        data_addr_ok,
   input  logic        data_data_ok,
   input  logic [31:0] data_rdata,
   output logic        data_cache_data_ok_01,
   output logic [31:0] data_cache_rdata_01,
   output logic        data_cache_data_ok_02,
   output logic [31:0] data_cache_rdata_02,
   output logic        protocol_err
);

   localparam int PTR_W = $clog2(MAX_OUTSTANDING);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, ISSUE1, ISSUE2, WAIT} state_t;

   typedef struct packed {
      logic        req;
      logic        wr;
      logic [1:0]  size;
      logic [3:0]  wstrb;
      logic [31:0] addr;
      logic [31:0] wdata;
   } slot_t;

   state_t             state_q, state_d;
   slot_t              slot_01_q, slot_01_d;
   slot_t              slot_02_q, slot_02_d;
   logic               tag_mem_q [MAX_OUTSTANDING];
   logic               tag_mem_d [MAX_OUTSTANDING];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               protocol_err_q, protocol_err_d;

   logic               fifo_full;
   logic               fifo_empty;
   logic               pop;
   logic               push;
   logic               head_tag;

   assign fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
   assign fifo_empty = (count_q == '0);
   assign pop        = data_data_ok && !fifo_empty;
   assign head_tag   = tag_mem_q[rd_ptr_q];

   assign pms_addr_ok           = (state_q == IDLE);
   assign data_cache_data_ok_01 = pop && !head_tag;
   assign data_cache_data_ok_02 = pop && head_tag;
   assign data_cache_rdata_01   = data_rdata;
   assign data_cache_rdata_02   = data_rdata;
   assign protocol_err          = protocol_err_q;

   always_comb begin
      state_d        = state_q;
      slot_01_d      = slot_01_q;
      slot_02_d      = slot_02_q;
      tag_mem_d      = tag_mem_q;
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      protocol_err_d = protocol_err_q;
      push           = 1'b0;
      data_req       = 1'b0;
      data_wr        = slot_01_q.wr;
      data_size      = slot_01_q.size;
      data_wstrb     = slot_01_q.wstrb;
      data_addr      = slot_01_q.addr;
      data_wdata     = slot_01_q.wdata;

      case (state_q)
         IDLE: begin
            if (pms_req_01 || pms_req_02) begin
               slot_01_d = {pms_req_01, pms_wr_01, pms_size_01, pms_wstrb_01,
                            pms_addr_01, pms_wdata_01};
               slot_02_d = {pms_req_02, pms_wr_02, pms_size_02, pms_wstrb_02,
                            pms_addr_02, pms_wdata_02};
               state_d   = pms_req_01 ? ISSUE1 : ISSUE2;
            end
         end
         ISSUE1: begin
            data_req = !fifo_full;
            if (!fifo_full && data_addr_ok) begin
               push    = 1'b1;
               state_d = slot_02_q.req ? ISSUE2 : WAIT;
            end
         end
         ISSUE2: begin
            data_req   = !fifo_full;
            data_wr    = slot_02_q.wr;
            data_size  = slot_02_q.size;
            data_wstrb = slot_02_q.wstrb;
            data_addr  = slot_02_q.addr;
            data_wdata = slot_02_q.wdata;
            if (!fifo_full && data_addr_ok) begin
               push    = 1'b1;
               state_d = WAIT;
            end
         end
         default: ;
      endcase

      // Tag records which slot issued each request; ISSUE2 pushes tag 1.
      if (push) begin
         tag_mem_d[wr_ptr_q] = (state_q == ISSUE2);
         wr_ptr_d            = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);

      if (data_data_ok && fifo_empty) begin
         protocol_err_d = 1'b1;
      end
      if (state_q == WAIT && count_d == '0) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         slot_01_q      <= '0;
         slot_02_q      <= '0;
         tag_mem_q      <= '{default: 1'b0};
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         protocol_err_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         slot_01_q      <= slot_01_d;
         slot_02_q      <= slot_02_d;
         tag_mem_q      <= tag_mem_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         count_q        <= count_d;
         protocol_err_q <= protocol_err_d;
      end
   end

endmodule

// File: tb/tb_dcache_dual_req_arbiter.sv
// Directed bench for dcache_dual_req_arbiter with a response scoreboard
// and a model of the in-order tag FIFO.
module tb_dcache_dual_req_arbiter;

   logic        clk;
   logic        reset;
   logic        pms_req_01, pms_wr_01, pms_req_02, pms_wr_02;
   logic [1:0]  pms_size_01, pms_size_02;
   logic [3:0]  pms_wstrb_01, pms_wstrb_02;
   logic [31:0] pms_addr_01, pms_wdata_01, pms_addr_02, pms_wdata_02;
   logic        pms_addr_ok;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr, data_wdata;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;
   logic        data_cache_data_ok_01, data_cache_data_ok_02;
   logic [31:0] data_cache_rdata_01, data_cache_rdata_02;
   logic        protocol_err;

   typedef struct {
      logic        ok1;
      logic        ok2;
      logic [31:0] rd;
   } exp_t;

   exp_t sb[$];
   int   model_tags[$];
   int   total;
   int   bad;

   dcache_dual_req_arbiter #(.MAX_OUTSTANDING(2)) dut (
      .clk(clk), .reset(reset),
      .pms_req_01(pms_req_01), .pms_wr_01(pms_wr_01), .pms_size_01(pms_size_01),
      .pms_wstrb_01(pms_wstrb_01), .pms_addr_01(pms_addr_01), .pms_wdata_01(pms_wdata_01),
      .pms_req_02(pms_req_02), .pms_wr_02(pms_wr_02), .pms_size_02(pms_size_02),
      .pms_wstrb_02(pms_wstrb_02), .pms_addr_02(pms_addr_02), .pms_wdata_02(pms_wdata_02),
      .pms_addr_ok(pms_addr_ok),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .data_cache_data_ok_01(data_cache_data_ok_01), .data_cache_rdata_01(data_cache_rdata_01),
      .data_cache_data_ok_02(data_cache_data_ok_02), .data_cache_rdata_02(data_cache_rdata_02),
      .protocol_err(protocol_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the run always ends even if the sequence stalls.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive a response this cycle; the model decides which slot it belongs to.
   task automatic respond(input logic [31:0] rd);
      int t;
      data_data_ok = 1'b1;
      data_rdata   = rd;
      if (model_tags.size() > 0) begin
         t = model_tags.pop_front();
         sb.push_back('{(t == 0), (t == 1), rd});
      end else begin
         sb.push_back('{1'b0, 1'b0, rd});
      end
   endtask

   task automatic issueOk(input int tag);
      data_addr_ok = 1'b1;
      model_tags.push_back(tag);
   endtask

   // Settle, compare response pulses against the scoreboard, advance one cycle.
   task automatic applyStimulus();
      exp_t e;
      #1;
      if (sb.size() > 0) e = sb.pop_front();
      else e = '{1'b0, 1'b0, 32'h0};
      checkOutput("data_ok_01", {31'b0, data_cache_data_ok_01}, {31'b0, e.ok1});
      checkOutput("data_ok_02", {31'b0, data_cache_data_ok_02}, {31'b0, e.ok2});
      if (e.ok1) checkOutput("rdata_01", data_cache_rdata_01, e.rd);
      if (e.ok2) checkOutput("rdata_02", data_cache_rdata_02, e.rd);
      @(posedge clk);
      #1;
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
   endtask

   task automatic clearPms();
      pms_req_01 = 1'b0;
      pms_req_02 = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      pms_req_01 = 0; pms_wr_01 = 0; pms_size_01 = 0; pms_wstrb_01 = 0;
      pms_addr_01 = 0; pms_wdata_01 = 0;
      pms_req_02 = 0; pms_wr_02 = 0; pms_size_02 = 0; pms_wstrb_02 = 0;
      pms_addr_02 = 0; pms_wdata_02 = 0;
      data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      $display("[TB] reset state");
      #1;
      checkOutput("rst_pms_addr_ok", {31'b0, pms_addr_ok}, 32'd1);
      checkOutput("rst_data_req", {31'b0, data_req}, 32'd0);
      checkOutput("rst_ok01", {31'b0, data_cache_data_ok_01}, 32'd0);
      checkOutput("rst_ok02", {31'b0, data_cache_data_ok_02}, 32'd0);
      checkOutput("rst_perr", {31'b0, protocol_err}, 32'd0);

      $display("[TB] load pair");
      pms_req_01 = 1; pms_wr_01 = 0; pms_size_01 = 2; pms_wstrb_01 = 4'hf; pms_addr_01 = 32'h1000;
      pms_req_02 = 1; pms_wr_02 = 0; pms_size_02 = 2; pms_wstrb_02 = 4'hf; pms_addr_02 = 32'h1004;
      applyStimulus();
      clearPms();
      checkOutput("p1_issue1_req", {31'b0, data_req}, 32'd1);
      checkOutput("p1_issue1_addr", data_addr, 32'h1000);
      checkOutput("p1_pms_addr_ok", {31'b0, pms_addr_ok}, 32'd0);
      issueOk(0);
      applyStimulus();
      checkOutput("p1_issue2_req", {31'b0, data_req}, 32'd1);
      checkOutput("p1_issue2_addr", data_addr, 32'h1004);
      respond(32'hAAAA0001);
      issueOk(1);
      applyStimulus();
      checkOutput("p1_wait_req", {31'b0, data_req}, 32'd0);
      checkOutput("p1_wait_pms_ok", {31'b0, pms_addr_ok}, 32'd0);
      respond(32'hBBBB0002);
      applyStimulus();
      checkOutput("p1_back_idle", {31'b0, pms_addr_ok}, 32'd1);

      $display("[TB] slot 02 only store");
      pms_req_02 = 1; pms_wr_02 = 1; pms_size_02 = 1; pms_wstrb_02 = 4'b0011;
      pms_addr_02 = 32'h2002; pms_wdata_02 = 32'h12345678;
      applyStimulus();
      clearPms();
      checkOutput("p2_req", {31'b0, data_req}, 32'd1);
      checkOutput("p2_wr", {31'b0, data_wr}, 32'd1);
      checkOutput("p2_wstrb", {28'b0, data_wstrb}, 32'h3);
      checkOutput("p2_addr", data_addr, 32'h2002);
      checkOutput("p2_wdata", data_wdata, 32'h12345678);
      issueOk(1);
      applyStimulus();
      respond(32'hCCCC0003);
      applyStimulus();
      checkOutput("p2_back_idle", {31'b0, pms_addr_ok}, 32'd1);

      $display("[TB] addr_ok withheld in ISSUE1");
      pms_req_01 = 1; pms_wr_01 = 1; pms_size_01 = 2; pms_wstrb_01 = 4'hf;
      pms_addr_01 = 32'h3000; pms_wdata_01 = 32'hDEADBEEF;
      applyStimulus();
      clearPms();
      for (int i = 0; i < 3; i++) begin
         pms_addr_01  = 32'h9999_0000 + i;
         pms_wdata_01 = 32'h5A5A_0000 + i;
         checkOutput("p3_hold_req", {31'b0, data_req}, 32'd1);
         checkOutput("p3_hold_addr", data_addr, 32'h3000);
         checkOutput("p3_hold_wdata", data_wdata, 32'hDEADBEEF);
         checkOutput("p3_hold_pms_ok", {31'b0, pms_addr_ok}, 32'd0);
         applyStimulus();
      end
      checkOutput("p3_still_req", {31'b0, data_req}, 32'd1);
      issueOk(0);
      applyStimulus();
      checkOutput("p3_wait_pms_ok", {31'b0, pms_addr_ok}, 32'd0);
      respond(32'h0000_0ACC);
      applyStimulus();
      checkOutput("p3_back_idle", {31'b0, pms_addr_ok}, 32'd1);

      $display("[TB] stray response while idle");
      respond(32'h5555_5555);
      applyStimulus();
      checkOutput("p5_perr_set", {31'b0, protocol_err}, 32'd1);
      applyStimulus();
      checkOutput("p5_perr_sticky", {31'b0, protocol_err}, 32'd1);

      $display("[TB] reset in ISSUE2 with one tag outstanding");
      pms_req_01 = 1; pms_wr_01 = 0; pms_addr_01 = 32'h4000;
      pms_req_02 = 1; pms_wr_02 = 0; pms_addr_02 = 32'h4004;
      applyStimulus();
      clearPms();
      issueOk(0);
      applyStimulus();
      checkOutput("p6_in_issue2", data_addr, 32'h4004);
      reset = 1'b1;
      model_tags.delete();
      sb.delete();
      applyStimulus();
      reset = 1'b0;
      checkOutput("p6_pms_addr_ok", {31'b0, pms_addr_ok}, 32'd1);
      checkOutput("p6_data_req", {31'b0, data_req}, 32'd0);
      checkOutput("p6_perr_clear", {31'b0, protocol_err}, 32'd0);
      respond(32'h6666_6666);
      applyStimulus();
      checkOutput("p6_perr_set", {31'b0, protocol_err}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dcache_dual_req_arbiter.md
Name: dcache_dual_req_arbiter

Overview:
- Memory-request side of the dual-issue data path: takes a load/store pair (slot 01 = older, slot 02 = younger) from the pre-memory stage.
- Serialises the pair in program order onto one SRAM-like data-cache port (req/addr_ok/data_ok).
- Steers each returned response back as per-slot data_ok_01/rdata_01 and data_ok_02/rdata_02 pulses, which the memory stage consumes.
- Sits between the pre-memory stage and the data cache / AXI bridge.

Parameters:
MAX_OUTSTANDING, 2, depth of in-order response tag FIFO (issued, not yet answered); power of two, ≥2.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
pms_req_01  in  1  slot 01 has a memory access
pms_wr_01  in  1  slot 01 is a store
pms_size_01  in  2  0=byte, 1=half, 2=word
pms_wstrb_01  in  4  store byte enables
pms_addr_01  in  32  address
pms_wdata_01  in  32  store data
pms_req_02, pms_wr_02, pms_size_02, pms_wstrb_02, pms_addr_02, pms_wdata_02  in  1/1/2/4/32/32  same fields for slot 02
pms_addr_ok  out  1  pair accepted this cycle when (pms_req_01|pms_req_02)
data_req  out  1  downstream request valid
data_wr  out  1  downstream write
data_size  out  2  downstream size
data_wstrb  out  4  downstream byte enables
data_addr  out  32  downstream address
data_wdata  out  32  downstream write data
data_addr_ok  in  1  downstream accepted request
data_data_ok  in  1  downstream response (read data or write ack), in request order
data_rdata  in  32  downstream read data
data_cache_data_ok_01  out  1  one-cycle response pulse for slot 01
data_cache_rdata_01  out  32  slot 01 read data, valid with pulse
data_cache_data_ok_02  out  1  one-cycle response pulse for slot 02
data_cache_rdata_02  out  32  slot 02 read data, valid with pulse
protocol_err  out  1  sticky: data_data_ok received with tag FIFO empty

Behaviour:
- FSM states: IDLE, ISSUE1, ISSUE2, WAIT. Reset → IDLE, tag FIFO empty, protocol_err=0.
- Reset mid-operation drops all pending requests and tags; no further data_ok pulses are emitted for them.
- pms_addr_ok = (state==IDLE), combinational. Out of reset it is therefore 1; data_req=0, both data_ok outputs=0.
- Pair acceptance in IDLE when (pms_req_01|pms_req_02):
  - Latch all fields of both slots plus req flags.
  - Next state: ISSUE1 if req_01, else ISSUE2 (slot-02-only pair skips ISSUE1).
- IDLE with neither req: no state change, nothing latched.
- ISSUE1:
  - data_req=1; data_* driven from the latched slot 01 registers.
  - On data_addr_ok: push tag 0; next state ISSUE2 if latched req_02, else WAIT.
  - data_req held with stable fields until addr_ok.
- ISSUE2: same as ISSUE1 using slot 02; on data_addr_ok push tag 1 → WAIT.
- Tag FIFO full (MAX_OUTSTANDING entries): data_req forced 0 in ISSUE1/ISSUE2 until a pop frees space.
- WAIT: → IDLE in the cycle the FIFO becomes empty (last pop). The next pair can be accepted the cycle after that.
- Outside ISSUE1/ISSUE2, data_req=0 and data_* are don't-care; the bench checks data_req only.
- Response steering (combinational, zero latency):
  - On data_data_ok with FIFO non-empty: pop head tag.
  - Tag 0 → data_cache_data_ok_01=1 and data_cache_rdata_01=data_rdata.
  - Tag 1 → data_cache_data_ok_02=1 and data_cache_rdata_02=data_rdata.
  - Never both pulses in one cycle.
  - rdata outputs equal data_rdata at all times; meaningful only with their pulse.
- Responses may arrive in any state with a non-empty FIFO, including ISSUE2 (slot 01 answered while slot 02 is still being issued).
- Simultaneous push (addr_ok) and pop (data_ok) in one cycle: both take effect; count unchanged; pop uses the pre-push head. A push into an empty FIFO cannot be popped the same cycle.
- data_data_ok with FIFO empty: ignored (no pulse), protocol_err set to 1 until reset.
- Stores are issued and acknowledged identically to loads; their data_ok pulse releases the memory stage.
- FIFO pointers wrap modulo MAX_OUTSTANDING. Count width is log2(MAX_OUTSTANDING)+1.

Test Plan:
- Load pair, addr_01=0x1000, addr_02=0x1004, downstream addr_ok same cycle, data_ok 1 cycle later with rdata 0xAAAA0001 then 0xBBBB0002 → data_ok_01 pulse with rdata_01=0xAAAA0001 precedes data_ok_02 pulse with 0xBBBB0002; pms_addr_ok returns to 1 the cycle after the second pulse.
- Slot 02 only (store, wstrb=4'b0011, addr=0x2002) → ISSUE1 skipped; first data_req carries wr=1, wstrb=0011, addr=0x2002; data_ok → only data_ok_02 pulses.
- addr_ok withheld 3 cycles in ISSUE1 → data_req held 1 with unchanged addr/wdata; pms_addr_ok stays 0 throughout.
- Slot 01 data_ok arrives in the same cycle slot 02 gets addr_ok → data_ok_01 pulse that cycle, tag 1 pushed; later data_ok → data_ok_02; FIFO count back to 0.
- data_data_ok asserted while IDLE → no pulse on either slot; protocol_err=1 and stays 1 until reset.
- reset asserted in ISSUE2 with one tag outstanding → next cycle state IDLE, data_req=0, pms_addr_ok=1; a following data_data_ok sets protocol_err rather than pulsing data_ok_01.
